// File: rtl/mc_seq_pkg.sv
// Shared types and constants for the multi-cycle RV32I sequencer.
// State codes are fixed so o_state can be decoded directly by debug tools.
package mc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_IF_TO   = 2'b01;
  localparam logic [1:0] TRAP_MEM_TO  = 2'b10;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b11;

  // Cycles per instruction with zero-wait memory.
  localparam int CPI_ALU_MIN  = 4;
  localparam int CPI_LDST_MIN = 5;

endpackage

// File: rtl/mc_sequencer_if.sv
// Single-port memory bus between the sequencer (master) and memory (slave).
// Handshake: o_mem_req is held high, with o_mem_we / o_mem_data stable, until
// the memory returns i_mem_ack for one cycle; the access completes in that ack
// cycle (read data is valid then). Ack in the first request cycle is legal and
// ack while no request is pending is ignored.
interface mc_sequencer_if;
  logic o_mem_req;
  logic o_mem_we;
  logic o_mem_data;
  logic i_mem_ack;

  modport master (output o_mem_req, output o_mem_we, output o_mem_data, input i_mem_ack);
  modport slave  (input o_mem_req, input o_mem_we, input o_mem_data, output i_mem_ack);
endinterface

// File: rtl/mc_seq_timeout.sv
// Memory wait counter shared by FETCH and MEM. Flags expiry in the cycle where
// the MEM_TIMEOUT-th consecutive wait cycle has no ack. MEM_TIMEOUT = 0 disables it.
module mc_seq_timeout #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [TO_W-1:0] r_cnt;

  // Count un-acked wait cycles; clear wins over count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign o_expired = 1'b0;
    end else begin : g_timeout
      localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT - 1);
      assign o_expired = i_en && (r_cnt == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle sequencer: FETCH, DECODE, EXEC, optional MEM, WB over one shared
// memory port. Traps on memory timeout or illegal instruction.
// Optional perf counters are built when MC_SEQ_PERF_EN is defined.
module mc_sequencer
  import mc_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_insn_vld,
  input  logic             i_is_load,
  input  logic             i_is_store,
  input  logic             i_reg_wen,
  mc_sequencer_if.master   io_mem,
  output logic             o_ir_we,
  output logic             o_mdr_we,
  output logic             o_pc_we,
  output logic             o_reg_we,
  output logic [2:0]       o_state,
  output logic             o_trap,
  output logic [1:0]       o_trap_cause,
  output logic [CNT_W-1:0] o_retired,
  output logic [CNT_W-1:0] o_cyc_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause;
  logic             w_trap_set;
  logic             w_retire;
  logic             w_wait;
  logic             w_to_en;
  logic             w_to_exp;
  logic             w_mem_req;
  logic             w_mem_we;
  logic             w_mem_data;
  logic [CNT_W-1:0] r_retired;

  assign w_wait  = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_to_en = w_wait && !io_mem.i_mem_ack;

  mc_seq_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (!w_to_en),
    .i_en      (w_to_en),
    .o_expired (w_to_exp)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state and Moore-style strobes qualified by ack and decoder flags.
  always_comb begin
    w_next     = r_state;
    w_trap_set = 1'b0;
    w_cause    = TRAP_NONE;
    w_retire   = 1'b0;
    w_mem_req  = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_data = 1'b0;
    o_ir_we    = 1'b0;
    o_mdr_we   = 1'b0;
    o_pc_we    = 1'b0;
    o_reg_we   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_run) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_mem_req = 1'b1;
        if (io_mem.i_mem_ack) begin
          o_ir_we = 1'b1;
          w_next  = ST_DECODE;
        end else if (w_to_exp) begin
          w_next     = ST_TRAP;
          w_trap_set = 1'b1;
          w_cause    = TRAP_IF_TO;
        end
      end
      ST_DECODE: begin
        if (!i_insn_vld) begin
          w_next     = ST_TRAP;
          w_trap_set = 1'b1;
          w_cause    = TRAP_ILLEGAL;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_next = (i_is_load || i_is_store) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        w_mem_req  = 1'b1;
        w_mem_data = 1'b1;
        w_mem_we   = i_is_store;
        if (io_mem.i_mem_ack) begin
          o_mdr_we = i_is_load;
          w_next   = ST_WB;
        end else if (w_to_exp) begin
          w_next     = ST_TRAP;
          w_trap_set = 1'b1;
          w_cause    = TRAP_MEM_TO;
        end
      end
      ST_WB: begin
        o_pc_we  = 1'b1;
        o_reg_we = i_reg_wen;
        w_retire = 1'b1;
        w_next   = i_run ? ST_FETCH : ST_IDLE;
      end
      ST_TRAP: begin
        w_next = ST_TRAP;
      end
      default: begin
        w_next     = ST_TRAP;
        w_trap_set = 1'b1;
        w_cause    = TRAP_ILLEGAL;
      end
    endcase
  end

  // Trap cause is captured on the way into TRAP and held until reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_cause <= TRAP_NONE;
    else if (w_trap_set) r_cause <= w_cause;
  end

  // Retired-instruction counter, bumped once per WB cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + CNT_W'(1);
  end

  assign io_mem.o_mem_req  = w_mem_req;
  assign io_mem.o_mem_we   = w_mem_we;
  assign io_mem.o_mem_data = w_mem_data;
  assign o_state           = r_state;
  assign o_trap            = (r_state == ST_TRAP);
  assign o_trap_cause      = r_cause;
  assign o_retired         = r_retired;

`ifdef MC_SEQ_PERF_EN
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Busy cycles (not IDLE/TRAP) and memory wait cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cyc_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if ((r_state != ST_IDLE) && (r_state != ST_TRAP)) r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
      if (w_to_en) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_cyc_cnt   = r_cyc_cnt;
  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_cyc_cnt   = '0;
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: per-instruction trace model, table vectors,
// random programs and hand-written trap / reset sequences.
module tb_mc_sequencer;
  import mc_seq_pkg::*;

  localparam int TO    = 16;
  localparam int CNT_W = 32;
  localparam int W     = 13;
`ifdef MC_SEQ_PERF_EN
  localparam logic [63:0] PERF_MASK = 64'h0000_0000_FFFF_FFFF;
`else
  localparam logic [63:0] PERF_MASK = 64'd0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic run, vld, ld, sto, wen;
  logic o_ir_we, o_mdr_we, o_pc_we, o_reg_we, o_trap;
  logic [2:0] o_state;
  logic [1:0] o_trap_cause;
  logic [CNT_W-1:0] o_retired, o_cyc_cnt, o_stall_cnt;

  mc_sequencer_if mem_bus ();

  mc_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_insn_vld(vld),
    .i_is_load(ld), .i_is_store(sto), .i_reg_wen(wen), .io_mem(mem_bus),
    .o_ir_we(o_ir_we), .o_mdr_we(o_mdr_we), .o_pc_we(o_pc_we), .o_reg_we(o_reg_we),
    .o_state(o_state), .o_trap(o_trap), .o_trap_cause(o_trap_cause),
    .o_retired(o_retired), .o_cyc_cnt(o_cyc_cnt), .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int busy;
  logic [W-1:0] exp_q[$];
  logic [5:0]   stim_q[$];   // {run, vld, ld, sto, wen, ack}
  logic [63:0]  exp_retired, exp_cyc, exp_stall;

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  function automatic logic [W-1:0] mk(logic [2:0] st, logic req, logic we, logic data,
                                      logic ir, logic mdr, logic pc, logic rw,
                                      logic trap, logic [1:0] cause);
    return {st, req, we, data, ir, mdr, pc, rw, trap, cause};
  endfunction

  function automatic logic [W-1:0] act_vec();
    return {o_state, mem_bus.o_mem_req, mem_bus.o_mem_we, mem_bus.o_mem_data,
            o_ir_we, o_mdr_we, o_pc_we, o_reg_we, o_trap, o_trap_cause};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int rand_lat();
    if ($urandom_range(0, 9) == 0) return 15;
    return int'($urandom_range(0, 4));
  endfunction

  // ---------------- reference model: per-instruction traces ----------------
  task automatic push(logic [5:0] s, logic [W-1:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic add_idle(logic run_v);
    push({run_v, rb(), rb(), rb(), rb(), rb()}, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
  endtask

  task automatic add_fetch_wait(int n);
    for (int i = 0; i < n; i++)
      push({rb(), rb(), rb(), rb(), rb(), 1'b0}, mk(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00));
  endtask

  task automatic add_fetch(int lat);
    add_fetch_wait(lat);
    push({rb(), rb(), rb(), rb(), rb(), 1'b1}, mk(3'd1, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00));
    exp_stall += 64'(lat);
    exp_cyc   += 64'(lat + 1);
  endtask

  task automatic add_decode(logic v, logic l, logic s, logic w);
    push({rb(), v, l, s, w, rb()}, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    exp_cyc += 1;
  endtask

  task automatic add_exec(logic l, logic s, logic w);
    push({rb(), 1'b1, l, s, w, rb()}, mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    exp_cyc += 1;
  endtask

  task automatic add_mem_wait(int n, logic l, logic s, logic w);
    for (int i = 0; i < n; i++)
      push({rb(), 1'b1, l, s, w, 1'b0}, mk(3'd4, 1, s, 1, 0, 0, 0, 0, 0, 2'b00));
  endtask

  task automatic add_mem(int lat, logic l, logic s, logic w);
    add_mem_wait(lat, l, s, w);
    push({rb(), 1'b1, l, s, w, 1'b1}, mk(3'd4, 1, s, 1, 0, l, 0, 0, 0, 2'b00));
    exp_stall += 64'(lat);
    exp_cyc   += 64'(lat + 1);
  endtask

  task automatic add_wb(logic run_next, logic l, logic s, logic w);
    push({run_next, 1'b1, l, s, w, rb()}, mk(3'd5, 0, 0, 0, 0, 0, 1, w, 0, 2'b00));
    exp_cyc     += 1;
    exp_retired += 1;
  endtask

  // kind: 0 ALU (writes rd), 1 load, 2 store, 3 branch
  task automatic add_insn(int kind, int f_lat, int m_lat, logic run_next);
    logic l, s, w;
    l = (kind == 1);
    s = (kind == 2);
    w = (kind == 0) || (kind == 1);
    add_fetch(f_lat);
    add_decode(1'b1, l, s, w);
    add_exec(l, s, w);
    if (l || s) add_mem(m_lat, l, s, w);
    add_wb(run_next, l, s, w);
  endtask

  task automatic add_trap(int n, logic [1:0] cause);
    for (int i = 0; i < n; i++)
      push({rb(), rb(), rb(), rb(), rb(), rb()}, mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 1, cause));
  endtask

  // ---------------- driver ----------------
  task automatic run_queue();
    logic [5:0]   s;
    logic [W-1:0] e;
    int idx;
    idx  = 0;
    busy = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(posedge clk);
      #1;
      {run, vld, ld, sto, wen, mem_bus.i_mem_ack} = s;
      #3;
      if (o_state != 3'd0) busy++;
      check($sformatf("cyc%0d_st%0d", idx, e[12:10]), 64'(act_vec()), 64'(e));
      idx++;
    end
  endtask

  task automatic check_counters(string tag);
    check({tag, "_retired"}, 64'(o_retired), 64'(exp_retired[CNT_W-1:0]));
    check({tag, "_cyc"},     64'(o_cyc_cnt),   exp_cyc & PERF_MASK);
    check({tag, "_stall"},   64'(o_stall_cnt), exp_stall & PERF_MASK);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    {run, vld, ld, sto, wen, mem_bus.i_mem_ack} = 6'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_retired = '0;
    exp_cyc     = '0;
    exp_stall   = '0;
    #3;
    check("reset_outputs", 64'(act_vec()), 64'd0);
    check_counters("reset");
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    int kind;
    int f_lat;
    int m_lat;
    int cpi;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    vecs[0] = '{0, 0,  0,  4};   // ADDI, zero wait
    vecs[1] = '{1, 0,  2,  7};   // LW, data ack on 3rd cycle
    vecs[2] = '{2, 0,  0,  5};   // SW, ack in first cycle
    vecs[3] = '{3, 1,  0,  5};   // branch, 1-wait fetch
    vecs[4] = '{0, 15, 0, 19};   // fetch ack on the last allowed cycle
    vecs[5] = '{1, 2, 15, 22};   // data ack on the last allowed cycle
    vecs[6] = '{2, 3,  4, 12};

    rst_n = 1'b1;
    {run, vld, ld, sto, wen, mem_bus.i_mem_ack} = 6'd0;
    #2;
    apply_reset();

    // Two back-to-back ADDIs: states 0,1,2,3,5,1,...
    add_idle(1'b1);
    add_insn(0, 0, 0, 1'b1);
    add_insn(0, 0, 0, 1'b0);
    add_idle(1'b0);
    run_queue();
    check_counters("addi2");

    for (int v = 0; v < 7; v++) begin
      add_idle(1'b1);
      add_insn(vecs[v].kind, vecs[v].f_lat, vecs[v].m_lat, 1'b0);
      add_idle(1'b0);
      run_queue();
      check($sformatf("cpi_vec%0d", v), 64'(busy), 64'(vecs[v].cpi));
      check_counters($sformatf("vec%0d", v));
    end

    // Random programs.
    for (int p = 0; p < 40; p++) begin
      n = int'($urandom_range(1, 5));
      add_idle(1'b1);
      for (int i = 0; i < n; i++)
        add_insn(int'($urandom_range(0, 3)), rand_lat(), rand_lat(), (i != n - 1));
      add_idle(1'b0);
      run_queue();
      check_counters($sformatf("rand%0d", p));
    end

    // Ten ADDIs with one fetch wait each.
    apply_reset();
    add_idle(1'b1);
    for (int i = 0; i < 10; i++) add_insn(0, 1, 0, (i != 9));
    add_idle(1'b0);
    run_queue();
    check("perf_retired10", 64'(o_retired), 64'd10);
`ifdef MC_SEQ_PERF_EN
    check("perf_cyc50",   64'(o_cyc_cnt),   64'd50);
    check("perf_stall10", 64'(o_stall_cnt), 64'd10);
`endif
    check_counters("perf");

    // Fetch timeout: 16 un-acked FETCH cycles then TRAP cause 01.
    apply_reset();
    add_idle(1'b1);
    add_fetch_wait(TO);
    add_trap(5, TRAP_IF_TO);
    run_queue();
    apply_reset();

    // Data timeout on a load.
    add_idle(1'b1);
    add_fetch(0);
    add_decode(1'b1, 1'b1, 1'b0, 1'b1);
    add_exec(1'b1, 1'b0, 1'b1);
    add_mem_wait(TO, 1'b1, 1'b0, 1'b1);
    add_trap(5, TRAP_MEM_TO);
    run_queue();
    check("memto_retired", 64'(o_retired), 64'd0);
    apply_reset();

    // Illegal instruction in DECODE.
    add_idle(1'b1);
    add_fetch(2);
    add_decode(1'b0, 1'b0, 1'b0, 1'b0);
    add_trap(6, TRAP_ILLEGAL);
    run_queue();
    apply_reset();

    // Reset in the middle of a fetch drops the request without a clock edge.
    add_idle(1'b1);
    add_fetch_wait(3);
    run_queue();
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_req",     64'(mem_bus.o_mem_req), 64'd0);
    check("rst_mid_state",   64'(o_state), 64'd0);
    check("rst_mid_retired", 64'(o_retired), 64'd0);
    mem_bus.i_mem_ack = 1'b0;
    run = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_retired = '0;
    exp_cyc     = '0;
    exp_stall   = '0;

    // Recovery after reset.
    add_idle(1'b1);
    add_insn(1, 1, 1, 1'b1);
    add_insn(2, 0, 3, 1'b0);
    add_idle(1'b0);
    run_queue();
    check_counters("recover");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Multi-cycle sequencer for the RV32I datapath. It shares one single-port memory between instruction fetch and load/store access, and steps each instruction through FETCH, DECODE, EXEC, optional MEM, then WB. Decode flags come from the existing combinational decoder. The block gates the IR, MDR, PC and register-file write enables, and traps on memory timeout or an illegal instruction.

Parameters:
MEM_TIMEOUT, 16, cycles without i_mem_ack before a memory trap; 0 disables the timeout
CNT_W, 32, width of the retire counter and the perf counters

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset
i_run  in  1  start/continue execution
i_insn_vld  in  1  decoder: legal instruction
i_is_load  in  1  decoder: load
i_is_store  in  1  decoder: store
i_reg_wen  in  1  decoder: instruction writes rd
i_mem_ack  in  1  memory completes the access this cycle; read data valid this cycle
o_mem_req  out  1  memory request
o_mem_we  out  1  memory write
o_mem_data  out  1  address select: 0 = PC (fetch), 1 = ALU result (data)
o_ir_we  out  1  latch instruction register
o_mdr_we  out  1  latch load data
o_pc_we  out  1  commit next PC
o_reg_we  out  1  register-file write
o_state  out  3  current state encoding
o_trap  out  1  sticky trap flag
o_trap_cause  out  2  01 fetch timeout, 10 data timeout, 11 illegal instruction
o_retired  out  CNT_W  retired-instruction count
o_cyc_cnt  out  CNT_W  cycle count (optional feature)
o_stall_cnt  out  CNT_W  memory-wait cycle count (optional feature)

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: state = IDLE, timeout counter = 0, o_retired = 0, o_trap = 0, o_trap_cause = 0. Every other output is 0.
- State encoding: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 7. Codes 6 and any other illegal code go to TRAP with cause 11.
- Output decode: all outputs except the counters are Moore outputs from the state, qualified combinationally by i_mem_ack and the decoder flags. Control outputs are 0 wherever not listed below.
- IDLE: no outputs asserted. Go to FETCH when i_run = 1.
- FETCH: o_mem_req = 1, o_mem_data = 0, o_mem_we = 0.
  - On i_mem_ack: o_ir_we = 1 in the same cycle, then go to DECODE.
- DECODE: one cycle. The IR is now stable.
  - i_insn_vld = 0: go to TRAP with cause 11.
  - Otherwise go to EXEC.
- EXEC: one cycle.
  - i_is_load or i_is_store: go to MEM.
  - Otherwise go to WB.
- MEM: o_mem_req = 1, o_mem_data = 1, o_mem_we = i_is_store.
  - On i_mem_ack: o_mdr_we = i_is_load, then go to WB.
- WB: one cycle. o_pc_we = 1, o_reg_we = i_reg_wen, o_retired increments by 1.
  - i_run = 1: go to FETCH.
  - i_run = 0: go to IDLE.
- TRAP: o_trap = 1 and o_trap_cause holds. All strobes are 0. The state stays in TRAP until i_rst_n is asserted.
- Timeout counter:
  - Clears on entry to FETCH or MEM and on i_mem_ack.
  - Increments on each FETCH or MEM cycle without ack.
  - When the counter equals MEM_TIMEOUT-1 with no ack in that cycle, go to TRAP: cause 01 from FETCH, 10 from MEM.
  - An ack in that same final cycle wins over the timeout.
- Memory request rules:
  - The memory latency is the number of cycles until i_mem_ack; ack in the first request cycle is legal.
  - o_mem_req stays high until ack; request attributes are stable while waiting.
  - i_mem_ack outside FETCH/MEM is ignored.
- Minimum CPI: 4 for ALU/branch/jump instructions and 5 for load/store, both with zero-wait memory.
- i_run = 0 mid-instruction is ignored; it is sampled only in IDLE and WB.
- Decoder inputs are required to be stable from DECODE through WB, which the IR guarantees.
- o_retired wraps modulo 2^CNT_W.
- Reset mid-access: o_mem_req drops immediately because the state goes to IDLE asynchronously. No commit occurs.

Optional Feature:
MC_SEQ_PERF_EN
- Defined:
  - o_cyc_cnt increments every cycle the state is not IDLE or TRAP.
  - o_stall_cnt increments every FETCH/MEM cycle without i_mem_ack.
  - Both reset to 0 and wrap modulo 2^CNT_W.
- Undefined: the ports still exist but are tied to 0, and no counter flops are built.

Decomposition:
- Package mc_seq_pkg holds:
  - the state enum (3-bit, codes above);
  - trap-cause localparams TRAP_NONE/TRAP_IF_TO/TRAP_MEM_TO/TRAP_ILLEGAL;
  - the CPI constants.
- Sub-module mc_seq_timeout: the wait counter with clear, enable and expired outputs. It is instantiated once and shared by FETCH and MEM.

Test Plan:
- Reset then i_run = 1 with ADDI (vld = 1, reg_wen = 1) and zero-wait ack -> states 0,1,2,3,5,1. o_ir_we in cycle 1, o_reg_we and o_pc_we in cycle 4, o_retired = 1.
- LW with a 3-cycle data ack -> MEM holds req = 1, we = 0, data = 1 for 3 cycles. o_mdr_we only on the ack cycle. WB o_reg_we = 1. CPI = 7.
- SW with ack in the first cycle -> o_mem_we = 1 for one cycle. WB o_reg_we = 0 and o_pc_we = 1.
- MEM_TIMEOUT = 16, no fetch ack -> TRAP after 16 FETCH cycles with cause 01. Ack on cycle 16 instead -> DECODE and no trap.
- i_insn_vld = 0 in DECODE -> TRAP with cause 11. No strobes afterwards. Asserting i_rst_n returns to IDLE with o_trap = 0.
- With MC_SEQ_PERF_EN defined, 10 ADDIs with 1-wait fetch -> o_retired = 10, o_stall_cnt = 10, o_cyc_cnt = 50.
